// File: rtl/gpio_seq_monitor.sv
// gpio_seq_monitor
//   Walks a programmable table of {expected, mask} patterns against a
//   synchronised GPIO bus. Each pattern must match on two consecutive cycles
//   to be accepted. Each pattern has its own cycle budget. The sequence ends
//   with a sticky pass after the final pattern, or a sticky fail on timeout.
//
//   Optional feature: define GPIO_SEQ_MONITOR_EDGE_LOG_EN to add edge_cnt.
//   edge_cnt is a saturating 16-bit count of cycles in which the synchronised
//   bus changed within the masked bits while busy.
//
// Ports
//   clk        : clock, rising edge
//   nrst       : asynchronous active-low reset
//   en         : enable qualifier; the sequence does not advance while low
//   start      : launches a sequence (ignored while busy)
//   cfg_we     : pattern-table write strobe
//   cfg_addr   : pattern-table write address
//   cfg_exp    : expected value to write
//   cfg_mask   : compare mask to write (1 = bit is checked)
//   cfg_last   : index of the final pattern, sampled on start
//   gpio_in    : asynchronous GPIO bus under observation
//   busy       : sequence in progress (WAIT_EN or CHECK)
//   pass       : sticky, every pattern matched
//   fail       : sticky, a pattern timed out
//   idx        : current pattern index, or the index of the failing pattern
//   fail_data  : synchronised bus value captured at timeout
//   edge_cnt   : (optional) masked edge counter
module gpio_seq_monitor #(
  parameter int WIDTH   = 34,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     en,
  input  logic                     start,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_exp,
  input  logic [WIDTH-1:0]         cfg_mask,
  input  logic [$clog2(DEPTH)-1:0] cfg_last,
  input  logic [WIDTH-1:0]         gpio_in,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic [WIDTH-1:0]         fail_data
`ifdef GPIO_SEQ_MONITOR_EDGE_LOG_EN
  ,
  output logic [15:0]              edge_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EN,
    CHECK,
    DONE_PASS,
    DONE_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW-1:0]     last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hit_q, hit_d;      // pattern matched on the previous CHECK cycle
  logic              busy_q, busy_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [WIDTH-1:0]  fail_data_q, fail_data_d;
  logic [WIDTH-1:0]  sync1_q, sync_q;

  logic [WIDTH-1:0]  exp_mem  [DEPTH];
  logic [WIDTH-1:0]  mask_mem [DEPTH];

  logic              match;
  logic              start_go;

  // NOTE: the pattern table is plain storage with no reset. A reset must keep
  // the programmed table, and leaving the reset off lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      exp_mem[cfg_addr]  <= cfg_exp;
      mask_mem[cfg_addr] <= cfg_mask;
    end
  end

  assign match    = ((sync_q ^ exp_mem[idx_q]) & mask_mem[idx_q]) == '0;
  assign start_go = start && (state_q == IDLE || state_q == DONE_PASS || state_q == DONE_FAIL);

  // NOTE: every _d gets its hold value first, so no path through the case
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    hit_d       = hit_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    fail_data_d = fail_data_q;

    case (state_q)
      IDLE, DONE_PASS, DONE_FAIL: begin
        if (start_go) begin
          state_d = WAIT_EN;
          idx_d   = '0;
          last_d  = cfg_last;
          cnt_d   = '0;
          hit_d   = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      WAIT_EN: begin
        if (en) state_d = CHECK;
      end
      CHECK: begin
        // With en low, the counter and match flag freeze in place.
        if (en) begin
          if (match && hit_q) begin
            // Acceptance takes priority over a timeout in the same cycle.
            if (idx_q == last_q) begin
              state_d = DONE_PASS;
              pass_d  = 1'b1;
            end else begin
              idx_d = idx_q + AW'(1);
              cnt_d = '0;
              hit_d = 1'b0;
            end
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d     = DONE_FAIL;
            fail_d      = 1'b1;
            fail_data_d = sync_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
            hit_d = match;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_EN) || (state_d == CHECK);
  end

  // NOTE: state registers use non-blocking assignment, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_data_q <= '0;
      sync1_q     <= '0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      busy_q      <= busy_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_data_q <= fail_data_d;
      sync1_q     <= gpio_in;
      sync_q      <= sync1_q;
    end
  end

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign idx       = idx_q;
  assign fail_data = fail_data_q;

`ifdef GPIO_SEQ_MONITOR_EDGE_LOG_EN
  logic [WIDTH-1:0] sync_prev_q;
  logic [15:0]      edge_cnt_q, edge_cnt_d;
  logic             masked_edge;

  assign masked_edge = |((sync_q ^ sync_prev_q) & mask_mem[idx_q]);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (start_go)
      edge_cnt_d = '0;
    else if (busy_q && masked_edge && edge_cnt_q != 16'hFFFF)
      edge_cnt_d = edge_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_prev_q <= '0;
      edge_cnt_q  <= '0;
    end else begin
      sync_prev_q <= sync_q;
      edge_cnt_q  <= edge_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: doc/gpio_seq_monitor.md
GPIO_SEQ_MONITOR -- requirements
Module: gpio_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 34, meaning the number of monitored GPIO bits, matching {GPIO[37:5], GPIO[0]}.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of expected-pattern entries (power of two, 2..64).
REQ-003 SHALL have parameter TIMEOUT, default 1000000, meaning the per-pattern cycle budget (must be at least 4).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: design-enabled qualifier; the sequence does not advance while low.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that launches a sequence.
REQ-008 SHALL have port cfg_we, input, 1 bit: pattern-table write strobe.
REQ-009 SHALL have port cfg_addr, input, $clog2(DEPTH) bits: pattern-table write address.
REQ-010 SHALL have port cfg_exp, input, WIDTH bits: expected value to write.
REQ-011 SHALL have port cfg_mask, input, WIDTH bits: compare mask to write (1 = bit is checked).
REQ-012 SHALL have port cfg_last, input, $clog2(DEPTH) bits: index of the final pattern, sampled on start.
REQ-013 SHALL have port gpio_in, input, WIDTH bits: asynchronous GPIO bus under observation.
REQ-014 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-015 SHALL have port pass, output, 1 bit: sticky; the sequence completed with every pattern matched.
REQ-016 SHALL have port fail, output, 1 bit: sticky; a pattern timed out.
REQ-017 SHALL have port idx, output, $clog2(DEPTH) bits: index of the current pattern, or of the failing pattern.
REQ-018 SHALL have port fail_data, output, WIDTH bits: synchronised gpio_in value captured at timeout.

Function
REQ-019 SHALL pass gpio_in through a two-flop synchroniser; the compare uses the second stage (sync).
REQ-020 SHALL define match as (sync & mask[idx]) == (exp[idx] & mask[idx]).
REQ-021 SHALL implement the states IDLE, WAIT_EN, CHECK, DONE_PASS and DONE_FAIL.
REQ-022 SHALL, in IDLE, on start: clear pass/fail, set idx=0, latch cfg_last, clear the timeout counter, and go to WAIT_EN.
REQ-023 SHALL, in WAIT_EN, go to CHECK on the first cycle en=1; the timeout counter does not run in WAIT_EN.
REQ-024 SHALL, in CHECK, require match on two consecutive cycles to accept the pattern; a single-cycle match does not count.
REQ-025 SHALL, on acceptance with idx<last: increment idx, clear the timeout counter, and clear the consecutive-match flag.
REQ-026 SHALL, on acceptance with idx==last, go to DONE_PASS.
REQ-027 SHALL, in CHECK, increment the timeout counter each cycle; when it reaches TIMEOUT-1 without acceptance, capture sync into fail_data and go to DONE_FAIL.
REQ-028 SHALL treat acceptance and timeout in the same cycle as acceptance.
REQ-029 SHALL, if en falls during CHECK, hold the timeout counter and the match flag and resume when en returns.
REQ-030 SHALL set pass=1 in DONE_PASS and fail=1 in DONE_FAIL; both hold until the next start or reset.
REQ-031 SHALL assert busy in WAIT_EN and CHECK only.
REQ-032 SHALL ignore start while busy.
REQ-033 SHALL, in DONE_*, accept start and restart the sequence with the same behaviour as from IDLE.
REQ-034 SHALL accept cfg_we in any state, taking effect on the next clock; a write to the active idx affects the compare one cycle later.
REQ-035 SHALL treat cfg_last=0 as a valid one-pattern sequence.

Reset
REQ-036 SHALL, on nrst low, immediately set: state=IDLE, busy=0, pass=0, fail=0, idx=0, fail_data=0, synchroniser=0, counters=0.
REQ-037 SHALL not clear the pattern table on reset; a reset mid-sequence aborts the sequence with no sticky result.

Configuration
REQ-038 SHALL, with GPIO_SEQ_MONITOR_EDGE_LOG_EN defined, add output edge_cnt (16 bits, reset 0, saturating).
REQ-039 SHALL, with GPIO_SEQ_MONITOR_EDGE_LOG_EN defined, increment edge_cnt on each cycle where sync differs from its previous value within the masked bits, while busy.
REQ-040 SHALL, with GPIO_SEQ_MONITOR_EDGE_LOG_EN defined, clear edge_cnt on start.
REQ-041 SHALL, without GPIO_SEQ_MONITOR_EDGE_LOG_EN, omit the edge_cnt port and its logic entirely.

Verification
REQ-042 SHALL cover: table {0x1/mask 0x1, 0x3/mask 0x3}, cfg_last=1, en=1, gpio_in driven 0x1 then 0x3 -> pass=1 after 2 accepts, idx=1, busy=0.
REQ-043 SHALL cover: TIMEOUT=16, gpio_in held 0x0 against expected 0x5 -> fail=1 exactly 16 cycles after CHECK entry, fail_data=0, idx=0.
REQ-044 SHALL cover: a one-cycle glitch to the expected value -> no accept; holding the value for 2 cycles after the synchroniser -> accept.
REQ-045 SHALL cover: en dropped for 50 cycles mid-CHECK with TIMEOUT=16 -> no fail; the counter resumes when en returns.
REQ-046 SHALL cover: nrst pulsed low mid-CHECK -> all outputs 0 immediately; a subsequent start reruns from idx=0 using the retained table.
REQ-047 SHALL cover, with the macro defined: 5 masked toggles and 3 unmasked toggles -> edge_cnt=5.
